// File: rtl/dcache_store_buffer_pkg.sv
// Shared encodings for the writeback -> dcache store path.
// The size codes are common to writeback, the store buffer and the dcache.
package dcache_store_buffer_pkg;

  localparam logic [1:0] SB_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SB_SIZE_WORD  = 2'b01;
  localparam logic [1:0] SB_SIZE_DWORD = 2'b10;
  localparam logic [1:0] SB_SIZE_QWORD = 2'b11;

  // Loads and stores are compared on 8-byte granules, whatever their size.
  localparam int SB_GRANULE_SHIFT = 3;

endpackage

// File: rtl/dcache_store_buffer_if.sv
// Bundle of the store-buffer bus signals: writeback store input, dcache write
// port and the load-conflict probe.
//
// Handshakes:
//   writeback side: a store transfers on a rising edge where wb_dcache_write and
//   In_write_ready are both high; writeback holds the store while ready is low.
//   dcache side: the head transfers on a rising edge where mem_wr_req and
//   mem_wr_ack are both high; the head is stable while req is high and ack low.
interface dcache_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              wb_dcache_write;
  logic [ADDR_W-1:0] wb_dcache_addr;
  logic [DATA_W-1:0] wb_dcache_data;
  logic [1:0]        wb_dcache_size;
  logic              In_write_ready;

  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [1:0]        mem_wr_size;
  logic              mem_wr_ack;

  logic              ld_chk_v;
  logic [ADDR_W-1:0] ld_chk_addr;
  logic              ld_conflict;
  logic              sb_empty;

  // Store buffer side.
  modport slave (
    input  wb_dcache_write, wb_dcache_addr, wb_dcache_data, wb_dcache_size,
    input  mem_wr_ack, ld_chk_v, ld_chk_addr,
    output In_write_ready, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_size,
    output ld_conflict, sb_empty
  );

  // Environment side (writeback + dcache).
  modport master (
    output wb_dcache_write, wb_dcache_addr, wb_dcache_data, wb_dcache_size,
    output mem_wr_ack, ld_chk_v, ld_chk_addr,
    input  In_write_ready, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_size,
    input  ld_conflict, sb_empty
  );
endinterface

// File: rtl/dcache_store_buffer_granule_match.sv
// One-entry granule comparator: flags a valid store whose 8-byte granule
// equals the load's granule.
module sb_granule_match
  import dcache_store_buffer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              valid,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              match
);

  // Compare granule numbers; the byte offset inside the granule is ignored.
  assign match = valid && ((entry_addr >> SB_GRANULE_SHIFT) == (load_addr >> SB_GRANULE_SHIFT));

endmodule

// File: rtl/dcache_store_buffer.sv
// In-order store buffer between writeback and the dcache write port.
// Circular FIFO of committed stores, drained one per ack, with a conservative
// load-overlap check against pending and same-cycle incoming stores.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  dcache_store_buffer_if.slave  sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [1:0]        size_q  [DEPTH];
  logic              valid_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              push;
  logic              pop;
  logic [DEPTH:0]    match;

  // Ready/req come from the registered count only: no same-cycle bypass.
  assign sb.In_write_ready = (count != CNT_W'(DEPTH));
  assign sb.mem_wr_req     = (count != '0);
  assign sb.sb_empty       = (count == '0);

  assign push = sb.wb_dcache_write && sb.In_write_ready;
  assign pop  = sb.mem_wr_req && sb.mem_wr_ack;

  assign sb.mem_wr_addr = addr_q[rd_ptr];
  assign sb.mem_wr_data = data_q[rd_ptr];
  assign sb.mem_wr_size = size_q[rd_ptr];

  // Entry storage, pointers and occupancy; reset discards everything pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        size_q[i]  <= SB_SIZE_BYTE;
        valid_q[i] <= 1'b0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // push and pop never target the same slot: push needs count < DEPTH,
      // pop needs count > 0, so wr_ptr != rd_ptr whenever both happen.
      if (push) begin
        addr_q[wr_ptr]  <= sb.wb_dcache_addr;
        data_q[wr_ptr]  <= sb.wb_dcache_data;
        size_q[wr_ptr]  <= sb.wb_dcache_size;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // One comparator per entry plus one for the store being accepted this cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_match
    sb_granule_match #(.ADDR_W(ADDR_W)) u_match (
      .valid      (valid_q[i]),
      .entry_addr (addr_q[i]),
      .load_addr  (sb.ld_chk_addr),
      .match      (match[i])
    );
  end

  sb_granule_match #(.ADDR_W(ADDR_W)) u_incoming_match (
    .valid      (push),
    .entry_addr (sb.wb_dcache_addr),
    .load_addr  (sb.ld_chk_addr),
    .match      (match[DEPTH])
  );

  assign sb.ld_conflict = sb.ld_chk_v && (|match);

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Self-checking bench for dcache_store_buffer: directed scenarios followed by
// randomized traffic, checked against a queue model of the pending stores.
module tb_dcache_store_buffer;
  import dcache_store_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int SB_W   = ADDR_W + DATA_W + 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dcache_store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb_if ();

  dcache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .sb  (sb_if)
  );

  // ---------------- scoreboard ----------------
  // Pending stores in commit order, packed {addr, data, size}.
  logic [SB_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic same_granule(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a / 8) == (b / 8);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                       input logic [1:0] size, input logic ack, input logic chk_v,
                       input logic [ADDR_W-1:0] chk_addr, input logic rst);
    sb_if.wb_dcache_write = wr;
    sb_if.wb_dcache_addr  = addr;
    sb_if.wb_dcache_data  = data;
    sb_if.wb_dcache_size  = size;
    sb_if.mem_wr_ack      = ack;
    sb_if.ld_chk_v        = chk_v;
    sb_if.ld_chk_addr     = chk_addr;
    RST                   = rst;
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, '0, '0, SB_SIZE_BYTE, ack, 1'b0, '0, 1'b0);
  endtask

  // Check outputs mid-cycle against the model, then advance one edge.
  task automatic step();
    logic            exp_ready;
    logic            exp_req;
    logic            exp_conf;
    logic            push;
    logic [SB_W-1:0] head;
    @(negedge CLK);
    exp_ready = (exp_q.size() < DEPTH);
    exp_req   = (exp_q.size() > 0);
    push      = sb_if.wb_dcache_write && exp_ready;
    exp_conf  = 1'b0;
    if (sb_if.ld_chk_v) begin
      foreach (exp_q[i])
        if (same_granule(exp_q[i][SB_W-1 -: ADDR_W], sb_if.ld_chk_addr)) exp_conf = 1'b1;
      if (push && same_granule(sb_if.wb_dcache_addr, sb_if.ld_chk_addr)) exp_conf = 1'b1;
    end
    check("write_ready", sb_if.In_write_ready, exp_ready);
    check("wr_req",      sb_if.mem_wr_req,     exp_req);
    check("sb_empty",    sb_if.sb_empty,       !exp_req);
    check("ld_conflict", sb_if.ld_conflict,    exp_conf);
    if (exp_req) begin
      head = exp_q[0];
      check("head_addr", sb_if.mem_wr_addr, head[SB_W-1 -: ADDR_W]);
      check("head_data", sb_if.mem_wr_data, head[DATA_W+1 -: DATA_W]);
      check("head_size", sb_if.mem_wr_size, head[1:0]);
    end
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
    end else begin
      if (exp_req && sb_if.mem_wr_ack) void'(exp_q.pop_front());
      if (push) exp_q.push_back({sb_if.wb_dcache_addr, sb_if.wb_dcache_data, sb_if.wb_dcache_size});
    end
    #1;
  endtask

  task automatic store(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                       input logic [1:0] size, input logic ack);
    drive(1'b1, addr, data, size, ack, 1'b0, '0, 1'b0);
    step();
  endtask

  task automatic drain();
    int budget;
    budget = 4 * DEPTH;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1'b1);
      step();
      budget--;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] c;
    logic              wr;
    logic              rst;

    idle(1'b0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    // Reset state
    #1;
    check("rst_ready", sb_if.In_write_ready, 1);
    check("rst_req",   sb_if.mem_wr_req,     0);
    check("rst_empty", sb_if.sb_empty,       1);
    check("rst_addr",  sb_if.mem_wr_addr,    0);
    check("rst_data",  sb_if.mem_wr_data,    0);
    check("rst_size",  sb_if.mem_wr_size,    0);
    drive(1'b0, '0, '0, SB_SIZE_BYTE, 1'b0, 1'b1, 32'h1000, 1'b0);
    #1;
    check("rst_conflict", sb_if.ld_conflict, 0);

    // 1: single store, held, then acked
    store(32'h1000, 64'hAB, SB_SIZE_BYTE, 1'b0);
    idle(1'b0); step();
    idle(1'b0); step();
    idle(1'b1); step();
    idle(1'b0); step();
    check("t1_empty", sb_if.sb_empty, 1);

    // 2: fill, hold the 5th, ack frees a slot only on the next cycle
    for (int i = 0; i < DEPTH; i++)
      store(32'h4000 + 32'(i * 8), 64'(i + 1), SB_SIZE_DWORD, 1'b0);
    check("t2_full_ready", sb_if.In_write_ready, 0);
    store(32'h4100, 64'h55, SB_SIZE_QWORD, 1'b0);
    store(32'h4100, 64'h55, SB_SIZE_QWORD, 1'b1);
    store(32'h4100, 64'h55, SB_SIZE_QWORD, 1'b0);
    check("t2_fifth_taken", exp_q.size(), DEPTH);
    drain();

    // 3: steady stream, one in and one out per cycle
    store(32'h5000, 64'h0, SB_SIZE_WORD, 1'b0);
    for (int i = 1; i <= 20; i++)
      store(32'h5000 + 32'(i * 4), 64'(i), SB_SIZE_WORD, 1'b1);
    check("t3_occupancy", exp_q.size(), 1);
    drain();

    // 4: load conflict checks
    store(32'h2004, 64'hC0FFEE, SB_SIZE_WORD, 1'b0);
    drive(1'b0, '0, '0, SB_SIZE_BYTE, 1'b0, 1'b1, 32'h2000, 1'b0); step();
    drive(1'b0, '0, '0, SB_SIZE_BYTE, 1'b0, 1'b1, 32'h2008, 1'b0); step();
    drive(1'b1, 32'h3000, 64'h77, SB_SIZE_BYTE, 1'b0, 1'b1, 32'h3007, 1'b0); step();
    drain();

    // 5: reset with pending stores and ack high
    for (int i = 0; i < 3; i++) store(32'h6000 + 32'(i * 16), 64'(i), SB_SIZE_BYTE, 1'b0);
    drive(1'b0, '0, '0, SB_SIZE_BYTE, 1'b1, 1'b0, '0, 1'b1); step();
    check("t5_empty", sb_if.sb_empty, 1);
    check("t5_ready", sb_if.In_write_ready, 1);
    check("t5_req",   sb_if.mem_wr_req, 0);
    repeat (3) begin idle(1'b1); step(); end

    // 6: ack without req, then a fresh store
    repeat (4) begin idle(1'b1); step(); end
    store(32'h7008, 64'hDEAD_BEEF_0123_4567, SB_SIZE_QWORD, 1'b0);
    idle(1'b0); step();
    drain();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      a   = 32'($urandom_range(0, 63)) << 2;
      c   = 32'($urandom_range(0, 63)) << 2;
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
        c = exp_q[$urandom_range(0, exp_q.size() - 1)][SB_W-1 -: ADDR_W] ^ 32'($urandom_range(0, 7));
      wr  = ($urandom_range(0, 99) < 60);
      rst = ($urandom_range(0, 99) < 2);
      drive(wr, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 1) == 1), c, rst);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
